// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_CH-input, WIDTH-bit stream multiplexer with round-robin
// arbitration and a one-entry registered output stage.
// Optional feature macro: STREAM_MUX_SEL_OVERRIDE_EN. Defining it adds
// sel_valid_i / sel_i, which force the grant to one channel.
//
// Handshake: a beat moves on any interface in a cycle where valid and ready
// are both high at the rising edge. A producer holds data stable while valid
// is high and ready is low. in_ready_o is one-hot or zero. It is high only for
// the granted channel, and only when the output register can take a beat.
// That happens when the register is empty or when it drains in the same cycle.
module stream_mux_rr #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH*WIDTH-1:0] in_data_i,
    input  logic [NUM_CH-1:0]       in_valid_i,
    output logic [NUM_CH-1:0]       in_ready_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
`ifdef STREAM_MUX_SEL_OVERRIDE_EN
    input  logic                    sel_valid_i,
    input  logic [SEL_W-1:0]        sel_i,
`endif
    output logic [SEL_W-1:0]        out_ch_o
);

    // One extra bit so that rr_ptr + offset can be folded back below NUM_CH.
    localparam int CW = SEL_W + 1;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             override_act;
    logic             transfer;
    logic [WIDTH-1:0] grant_data;
    logic [SEL_W-1:0] rr_next;
    logic [CW-1:0]    cand;

    // The output register accepts a beat when it is empty or draining now.
    assign load = !out_valid_q || out_ready_i;

    // Round-robin search from rr_ptr. The override, when present, takes priority.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        override_act = 1'b0;
        cand         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= CW'(NUM_CH)) begin
                cand = cand - CW'(NUM_CH);
            end
            if (!grant_valid && in_valid_i[cand[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[SEL_W-1:0];
            end
        end
`ifdef STREAM_MUX_SEL_OVERRIDE_EN
        if (sel_valid_i) begin
            override_act = 1'b1;
            grant_idx    = sel_i;
            // An out-of-range or idle selected channel gives no grant at all.
            if ({1'b0, sel_i} < CW'(NUM_CH)) begin
                grant_valid = in_valid_i[sel_i];
            end else begin
                grant_valid = 1'b0;
            end
        end
`endif
    end

    assign transfer = load && grant_valid;

    // Pick the granted channel's data. The loop keeps every slice index constant.
    always_comb begin
        grant_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_idx == SEL_W'(c)) begin
                grant_data = in_data_i[c*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready to the granted producer. Nothing is accepted while in reset.
    always_comb begin
        in_ready_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst_ni && transfer && grant_idx == SEL_W'(c)) begin
                in_ready_o[c] = 1'b1;
            end
        end
    end

    // Pointer to the channel after the winner, wrapping at NUM_CH-1.
    assign rr_next = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

    // Next state: a load replaces the beat, a drain clears valid, and a stall holds.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q && !out_ready_i;
        rr_ptr_d    = rr_ptr_q;
        if (transfer) begin
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            // Override transfers leave the round-robin order untouched.
            if (!override_act) begin
                rr_ptr_d = rr_next;
            end
        end
    end

    // State registers with synchronous active-low reset. The reset drops any held beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;

endmodule
